// File: rtl/boot_reconfig_seq.sv
// Boot reconfiguration sequencer: waits for the bootloader SPI to go quiet, optionally wakes
// the flash, then pulses PROGRAMN. Optional flash wake command enabled by BOOT_SEQ_FLASH_WAKE_EN.
module boot_reconfig_seq #(
   parameter int          CS_IDLE_CYCLES = 16,
   parameter int          HOLD_CYCLES    = 480,
   parameter int          PROG_CYCLES    = 96,
   parameter logic [7:0]  WAKE_CMD       = 8'hAB
) (
   input  logic clk_48mhz,
   input  logic reset,
   input  logic boot_req,
   input  logic bl_spi_sck,
   input  logic bl_spi_cs,
   input  logic bl_spi_mosi,
   output logic spi_sck,
   output logic spi_cs,
   output logic spi_mosi,
   output logic programn,
   output logic busy
);

   localparam int MAX_A = (CS_IDLE_CYCLES > HOLD_CYCLES) ? CS_IDLE_CYCLES : HOLD_CYCLES;
   localparam int MAX_B = (MAX_A > PROG_CYCLES) ? MAX_A : PROG_CYCLES;
   localparam int MAX_C = (MAX_B > 32) ? MAX_B : 32;
   localparam int CNT_W = $clog2(MAX_C);

   localparam logic [CNT_W-1:0] CS_LAST   = CNT_W'(CS_IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_CS, S_SEND, S_HOLD, S_PROG, S_DONE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             boot_q;
   logic             programn_q;
   logic             busy_q;
   logic             request;

   assign request = boot_req & ~boot_q;

`ifdef BOOT_SEQ_FLASH_WAKE_EN
   localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(31);

   logic             own_q;
   logic             sck_q;
   logic             cs_q;
   logic             mosi_q;
   logic [CNT_W-1:0] cnt_d;

   assign cnt_d = cnt_q + CNT_W'(1);
`else
   logic unused_wake;
   assign unused_wake = ^WAKE_CMD;
`endif

   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         boot_q     <= 1'b1;
         programn_q <= 1'b1;
         busy_q     <= 1'b0;
`ifdef BOOT_SEQ_FLASH_WAKE_EN
         own_q      <= 1'b0;
         sck_q      <= 1'b0;
         cs_q       <= 1'b1;
         mosi_q     <= 1'b0;
`endif
      end else begin
         boot_q <= boot_req;
         case (state_q)
            S_IDLE: begin
               if (request) begin
                  state_q <= S_WAIT_CS;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_WAIT_CS: begin
               if (!bl_spi_cs) begin
                  cnt_q <= '0;
               end else if (cnt_q == CS_LAST) begin
                  cnt_q <= '0;
`ifdef BOOT_SEQ_FLASH_WAKE_EN
                  // Preload the first bit so SEND outputs are valid from its first cycle.
                  state_q <= S_SEND;
                  own_q   <= 1'b1;
                  sck_q   <= 1'b0;
                  cs_q    <= 1'b0;
                  mosi_q  <= WAKE_CMD[7];
`else
                  state_q <= S_HOLD;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`ifdef BOOT_SEQ_FLASH_WAKE_EN
            S_SEND: begin
               if (cnt_q == SEND_LAST) begin
                  state_q <= S_HOLD;
                  cnt_q   <= '0;
                  own_q   <= 1'b0;
                  cs_q    <= 1'b1;
                  sck_q   <= 1'b0;
               end else begin
                  // Four cycles per bit: sck low for two, high for two.
                  cnt_q  <= cnt_d;
                  sck_q  <= cnt_d[1];
                  mosi_q <= WAKE_CMD[3'd7 - cnt_d[4:2]];
               end
            end
`endif
            S_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_q    <= S_PROG;
                  cnt_q      <= '0;
                  programn_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_PROG: begin
               if (cnt_q == PROG_LAST) begin
                  state_q    <= S_DONE;
                  cnt_q      <= '0;
                  programn_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: ;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef BOOT_SEQ_FLASH_WAKE_EN
   assign spi_sck  = own_q ? sck_q  : bl_spi_sck;
   assign spi_cs   = own_q ? cs_q   : bl_spi_cs;
   assign spi_mosi = own_q ? mosi_q : bl_spi_mosi;
`else
   assign spi_sck  = bl_spi_sck;
   assign spi_cs   = bl_spi_cs;
   assign spi_mosi = bl_spi_mosi;
`endif
   assign programn = programn_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_boot_reconfig_seq.sv
// Bench for boot_reconfig_seq: vector table, directed corner sequences and random stimulus
// against a timeline model (phase offsets computed from the request time).
module tb_boot_reconfig_seq;

   localparam int         CS = 16;
   localparam int         H  = 480;
   localparam int         P  = 96;
   localparam logic [7:0] WK = 8'hAB;
`ifdef BOOT_SEQ_FLASH_WAKE_EN
   localparam int S = 32;
`else
   localparam int S = 0;
`endif

   logic clk = 1'b0;
   logic rst, boot, bsck, bcs, bmosi;
   logic spi_sck, spi_cs, spi_mosi, programn, busy;

   boot_reconfig_seq #(.CS_IDLE_CYCLES(CS), .HOLD_CYCLES(H), .PROG_CYCLES(P), .WAKE_CMD(WK)) dut (
      .clk_48mhz(clk), .reset(rst), .boot_req(boot),
      .bl_spi_sck(bsck), .bl_spi_cs(bcs), .bl_spi_mosi(bmosi),
      .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
      .programn(programn), .busy(busy)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: phase 0 idle, 1 waiting for quiet cs, 2 timed run (t counts from its start), 3 done.
   int ph    = 0;
   int run   = 0;
   int t     = 0;
   bit bprev = 1'b1;

   int stepn     = 0;
   int lows      = 0;
   int first_low = -1;

   typedef struct {
      logic       b, sck, cs, mosi;
      logic [4:0] exp;
   } vec_t;
   vec_t tbl[8];

   function automatic logic [4:0] model_out(input logic sck, input logic cs, input logic mosi);
      logic [4:0] o;
      logic [7:0] wk;
      wk = WK;
      o  = {sck, cs, mosi, 1'b1, (ph != 0)};
      if (ph == 2 && t < S) begin
         o[4] = ((t % 4) >= 2);
         o[3] = 1'b0;
         o[2] = wk[7 - t / 4];
      end
      if (ph == 2 && t >= S + H && t < S + H + P) o[1] = 1'b0;
      return o;
   endfunction

   task automatic model_reset();
      ph = 0; run = 0; t = 0; bprev = 1'b1;
   endtask

   task automatic model_tick(input logic b, input logic cs);
      bit req;
      req   = b & ~bprev;
      bprev = b;
      case (ph)
         0: if (req) begin ph = 1; run = 0; end
         1: begin
            if (cs) begin
               run++;
               if (run == CS) begin ph = 2; t = 0; end
            end else run = 0;
         end
         2: begin
            t++;
            if (t == S + H + P) ph = 3;
         end
         default: ;
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at step %0d: actual=%0h required=%0h", name, stepn, act, exp);
      end
   endtask

   task automatic step(input logic b, input logic sck, input logic cs, input logic mosi, input logic r);
      @(negedge clk);
      boot = b; bsck = sck; bcs = cs; bmosi = mosi; rst = r;
      #1;
      if (r) model_reset();
      check("outputs", {27'd0, spi_sck, spi_cs, spi_mosi, programn, busy}, {27'd0, model_out(sck, cs, mosi)});
      if (programn === 1'b0) begin
         if (first_low < 0) first_low = stepn;
         lows++;
      end
      stepn++;
      @(posedge clk);
      if (!r) model_tick(b, cs);
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_hi(input int n, input logic b);
      for (int i = 0; i < n; i++) step(b, rb(), 1'b1, rb(), 1'b0);
   endtask

   initial begin
      int kreq;
      int guard;
      rst = 1'b1; boot = 1'b1; bsck = 1'b0; bcs = 1'b1; bmosi = 1'b0;

      // Reset state and pass-through while held in reset.
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

      // boot_req high through reset release: idle, pure pass-through.
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00010};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10010};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01010};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00110};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b11110};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b11010};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b01110};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b10110};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         boot = tbl[i].b; bsck = tbl[i].sck; bcs = tbl[i].cs; bmosi = tbl[i].mosi; rst = 1'b0;
         #1;
         check("table", {27'd0, spi_sck, spi_cs, spi_mosi, programn, busy}, {27'd0, tbl[i].exp});
         stepn++;
         @(posedge clk);
         model_tick(tbl[i].b, tbl[i].cs);
      end

      // Full sequence with extra boot edges during HOLD and DONE.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      lows = 0; first_low = -1;
      kreq = stepn;
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int j = 1; j < CS + S + H + P + 40; j++) begin
         logic b;
         b = !(j == CS + S + 20 || j == CS + S + H + P + 20);
         step(b, rb(), 1'b1, rb(), 1'b0);
      end
      check("pulse_width", lows, P);
      check("pulse_start", first_low - kreq, 1 + CS + S + H);
      check("busy_done", {31'd0, busy}, 32'd1);

      // cs chatter during WAIT_CS delays entry until cs stays high.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 60; j++) step(1'b1, rb(), (j % 10) != 9, rb(), 1'b0);
      check("chatter_wait", ph, 1);
      run_hi(CS + S + 20, 1'b1);

      // Asynchronous reset twelve cycles into the timed run.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      guard = 0;
      while (!(ph == 2 && t == 12) && guard < 200) begin
         step(1'b1, rb(), 1'b1, rb(), 1'b0);
         guard++;
      end
      check("reach_t12", guard < 200, 1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("rst_mid_cs", {31'd0, spi_cs}, 32'd1);
      check("rst_mid_busy", {30'd0, programn, busy}, 32'd2);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      lows = 0; first_low = -1;
      kreq = stepn;
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      run_hi(CS + S + H + P + 10, 1'b1);
      check("restart_width", lows, P);
      check("restart_start", first_low - kreq, 1 + CS + S + H);

      // Random stimulus against the model.
      for (int i = 0; i < 6000; i++) begin
         logic b, c, r;
         b = ($urandom_range(0, 9) < 4);
         c = ($urandom_range(0, 29) != 0);
         r = ($urandom_range(0, 799) == 0);
         step(b, rb(), c, rb(), r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
